game_input_conditioner: RTL

//  Conditions the raw board pushbuttons for the memory game FSM: 2-FF sync, debounce and

---
 rtl/game_input_conditioner.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/game_input_conditioner.sv
// rtl/game_input_conditioner.sv - button sync, debounce, auto-repeat and move arbiter for the memory game
// One gic_button per raw button; the top serialises direction/Select events into single pulses.

module gic_button #(
    parameter int CNT_W      = 26,
    parameter int DEB_COUNT  = 500_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 20_000_000,
    parameter bit DO_REPEAT  = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_level,
    output logic o_ev,
    output logic o_db
);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEB        = CNT_W'(DEB_COUNT);
    localparam logic [CNT_W-1:0] C_RPT_DELAY  = CNT_W'(RPT_DELAY);
    localparam logic [CNT_W-1:0] C_RPT_RELOAD = CNT_W'(RPT_DELAY - RPT_PERIOD);

    typedef enum logic [2:0] {S_IDLE, S_PWAIT, S_PULSE, S_HOLD, S_RWAIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_t;
    logic [CNT_W-1:0] w_t_nxt;
    logic [CNT_W-1:0] w_t_inc;

    assign w_t_inc = (&r_t) ? r_t : r_t + C_ONE;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        o_ev        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_level) begin
                    w_state_nxt = S_PWAIT;
                    w_t_nxt     = C_ONE;
                end
            end
            S_PWAIT: begin
                if (!i_level) begin
                    w_state_nxt = S_IDLE;
                    w_t_nxt     = '0;
                end else if (r_t == C_DEB) begin
                    w_state_nxt = S_PULSE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = w_t_inc;
                end
            end
            S_PULSE: begin
                o_ev        = 1'b1;
                w_state_nxt = S_HOLD;
                w_t_nxt     = '0;
            end
            S_HOLD: begin
                if (!i_level) begin
                    w_state_nxt = S_RWAIT;
                    w_t_nxt     = C_ONE;
                end else if (DO_REPEAT) begin
                    // Event fires as the count reaches the delay; reloading keeps the period without a second compare.
                    if (w_t_inc == C_RPT_DELAY) begin
                        o_ev    = 1'b1;
                        w_t_nxt = C_RPT_RELOAD;
                    end else begin
                        w_t_nxt = w_t_inc;
                    end
                end
            end
            S_RWAIT: begin
                if (i_level) begin
                    w_state_nxt = S_HOLD;
                    w_t_nxt     = '0;
                end else if (r_t == C_DEB) begin
                    w_state_nxt = S_IDLE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = w_t_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    assign o_db = (r_state == S_PULSE) || (r_state == S_HOLD) || (r_state == S_RWAIT);
endmodule

module game_input_conditioner #(
    parameter int CNT_W      = 26,
    parameter int DEB_COUNT  = 500_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 20_000_000,
    parameter int REPEAT_EN  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btn_u,
    input  logic       i_btn_d,
    input  logic       i_btn_l,
    input  logic       i_btn_r,
    input  logic       i_btn_c,
    input  logic       i_btn_s,
    input  logic       i_accept,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic       o_select,
    output logic       o_start,
    output logic [5:0] o_db_level
);
    // Button vectors are ordered {S,C,R,L,D,U}; arbiter vectors are {Sel,U,D,L,R}.
    logic [5:0] w_raw;
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [5:0] w_ev;
    logic [5:0] w_db;
    logic [4:0] w_req;
    logic [4:0] w_grant;
    logic [4:0] r_pend;
    logic [4:0] r_out;
    logic       r_start_d;
    logic       r_start;

    assign w_raw = {i_btn_s, i_btn_c, i_btn_r, i_btn_l, i_btn_d, i_btn_u};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_btn
        gic_button #(
            .CNT_W      (CNT_W),
            .DEB_COUNT  (DEB_COUNT),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .DO_REPEAT  ((g < 4) && (REPEAT_EN != 0))
        ) u_btn (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_level   (r_sync2[g]),
            .o_ev      (w_ev[g]),
            .o_db      (w_db[g])
        );
    end

    assign w_req = {w_ev[4], w_ev[0], w_ev[1], w_ev[2], w_ev[3]};

    always_comb begin
        w_grant = '0;
        if (r_pend[4])      w_grant = 5'b10000;
        else if (r_pend[3]) w_grant = 5'b01000;
        else if (r_pend[2]) w_grant = 5'b00100;
        else if (r_pend[1]) w_grant = 5'b00010;
        else if (r_pend[0]) w_grant = 5'b00001;
    end

    // Start bypasses the arbiter but is delayed two stages to match the move-pulse latency.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend    <= '0;
            r_out     <= '0;
            r_start_d <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_start_d <= w_ev[5];
            r_start   <= r_start_d;
            if (!i_accept) begin
                r_pend <= '0;
                r_out  <= '0;
            end else begin
                r_pend <= (r_pend & ~w_grant) | w_req;
                r_out  <= w_grant;
            end
        end
    end

    assign o_select   = r_out[4];
    assign o_up       = r_out[3];
    assign o_down     = r_out[2];
    assign o_left     = r_out[1];
    assign o_right    = r_out[0];
    assign o_start    = r_start;
    assign o_db_level = w_db;
endmodule
